// File: rtl/matrix_outer_update_if.sv
// Handshake and data bundle for the rank-1 matrix update block.
// The master side supplies operands and the start request; the slave side
// returns the registered result matrix and the one-cycle done pulse.
interface matrix_outer_update_if #(
    parameter int WIDTH = 16,
    parameter int nos   = 4
);
    logic             startMult;
    logic             subMode;
    logic [WIDTH-1:0] C   [0:nos-1][0:nos-1];
    logic [WIDTH-1:0] u   [0:nos-1];
    logic [WIDTH-1:0] v   [0:nos-1];
    logic [WIDTH-1:0] Res [0:nos-1][0:nos-1];
    logic             endMult;

    modport master (
        output startMult, subMode, C, u, v,
        input  Res, endMult
    );

    modport slave (
        input  startMult, subMode, C, u, v,
        output Res, endMult
    );
endinterface

// File: rtl/matrix_outer_update.sv
// Sequential rank-1 update Res = C +/- u*v^T, one result row per clock.
// Operands are captured on acceptance so the caller may change them while
// the rows are being produced; rows not yet written read as zero.
module matrix_outer_update #(
    parameter int WIDTH     = 16,
    parameter int nos       = 4,
    parameter int intDigits = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_outer_update_if.slave  bus
);
    localparam int FRAC = WIDTH - intDigits;
    localparam int SW   = (nos > 1) ? $clog2(nos) : 1;
    localparam logic [SW-1:0] LAST = SW'(nos - 1);

    typedef enum logic [1:0] {
        IDLE,
        ONMULT,
        ENDMULT
    } state_t;

    state_t                  state;
    logic [SW-1:0]           subI;
    logic                    subr;
    logic [WIDTH-1:0]        Cr [0:nos-1][0:nos-1];
    logic [WIDTH-1:0]        ur [0:nos-1];
    logic [WIDTH-1:0]        vr [0:nos-1];

    logic signed [2*WIDTH-1:0] prod   [0:nos-1];
    logic        [WIDTH-1:0]   term   [0:nos-1];
    logic        [WIDTH-1:0]   rowVal [0:nos-1];

    // Current row: full-width signed product, arithmetic shift back to the
    // element's fixed-point scale, keep the low WIDTH bits, then wrap-add/sub.
    always_comb begin
        for (int j = 0; j < nos; j++) begin
            prod[j]   = '0;
            term[j]   = '0;
            rowVal[j] = '0;
            prod[j]   = $signed(ur[subI]) * $signed(vr[j]);
            term[j]   = WIDTH'(prod[j] >>> FRAC);
            rowVal[j] = subr ? (Cr[subI][j] - term[j]) : (Cr[subI][j] + term[j]);
        end
    end

    // Control FSM with operand capture, row write-back and registered done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            subI        <= '0;
            subr        <= 1'b0;
            bus.endMult <= 1'b0;
            for (int i = 0; i < nos; i++) begin
                ur[i] <= '0;
                vr[i] <= '0;
                for (int j = 0; j < nos; j++) begin
                    Cr[i][j]      <= '0;
                    bus.Res[i][j] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    bus.endMult <= 1'b0;
                    if (bus.startMult) begin
                        subr <= bus.subMode;
                        subI <= '0;
                        for (int i = 0; i < nos; i++) begin
                            ur[i] <= bus.u[i];
                            vr[i] <= bus.v[i];
                            for (int j = 0; j < nos; j++) begin
                                Cr[i][j]      <= bus.C[i][j];
                                bus.Res[i][j] <= '0;
                            end
                        end
                        state <= ONMULT;
                    end
                end
                ONMULT: begin
                    for (int j = 0; j < nos; j++) begin
                        bus.Res[subI][j] <= rowVal[j];
                    end
                    if (subI == LAST) begin
                        state       <= ENDMULT;
                        bus.endMult <= 1'b1;
                    end else begin
                        subI <= subI + SW'(1);
                    end
                end
                ENDMULT: begin
                    state       <= IDLE;
                    bus.endMult <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    bus.endMult <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/matrix_outer_update.md
# matrix_outer_update

Sequential rank-1 matrix update for the Kalman filter datapath. It computes Res = C ± u·vᵀ, the outer product of an nx1 column vector and a 1xn row vector, added to or subtracted from an nxn matrix. It produces one output row per clock. It is the column-times-row counterpart of the existing matrix-times-vector multiplier and uses the same startMult/endMult handshake. It serves covariance updates such as P − K·(H·P) and builds matrices from vectors.

## Interface
Parameters:
- WIDTH, 16: element width, signed two's-complement fixed point.
- nos, 4: matrix/vector dimension (number of states), ≥ 2.
- intDigits, 16: integer bits per element; FRAC = WIDTH − intDigits fractional bits; 1 ≤ intDigits ≤ WIDTH.

Ports (clk and rst_n first):
- clk, input, 1: single clock, all logic on rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- startMult, input, 1: request; sampled only in IDLE.
- subMode, input, 1: 0 → C + u·vᵀ, 1 → C − u·vᵀ; captured with operands.
- C, input, [WIDTH-1:0] [0:nos-1][0:nos-1]: base matrix.
- u, input, [WIDTH-1:0] [0:nos-1]: column vector.
- v, input, [WIDTH-1:0] [0:nos-1]: row vector.
- Res, output, [WIDTH-1:0] [0:nos-1][0:nos-1]: result matrix, registered.
- endMult, output, 1: one-cycle done pulse.

## Operation
- States:
  - IDLE: startMult=1 → ONMULT, otherwise stay in IDLE.
  - ONMULT: row counter subI==nos−1 → ENDMULT, otherwise stay in ONMULT.
  - ENDMULT: always → IDLE.
- On the accepting edge (IDLE and startMult=1):
  - C, u, v and subMode are copied into internal registers.
  - subI is cleared to 0.
  - All Res elements are cleared to 0.
- The block does not read input ports after acceptance. The caller may change them freely while the operation runs.
- Each ONMULT edge writes row subI for all j in parallel:
  - Res[subI][j] = Cr[subI][j] ± trunc(ur[subI]·vr[j]).
  - subI then increments.
  - Rows not yet written stay 0.
- Arithmetic:
  - Full 2·WIDTH signed product.
  - Arithmetic right shift by FRAC.
  - Keep the low WIDTH bits.
  - Add or subtract modulo 2^WIDTH.
  - No rounding and no saturation. Overflow wraps.
- Res holds its value from ENDMULT until the next accepting edge.
- endMult = (state == ENDMULT).
- startMult in ONMULT or ENDMULT is ignored, and nothing is queued.
- The synthesis default is nos ≥ 2. subI width is $clog2(nos).

## Timing
- Reset (rst_n=0 at an edge):
  - state goes to IDLE, subI to 0, all Res to 0, endMult to 0.
  - Reset overrides every other condition, including a reset in the middle of an operation.
  - No endMult pulse follows an aborted operation.
- Start sampled at edge k:
  - Row i is written at edge k+1+i.
  - endMult is high from edge k+nos to edge k+nos+1.
  - Latency is nos+1 cycles.
- All of Res is valid and stable while endMult is high.
- With startMult held high, operations repeat every nos+2 cycles. The IDLE cycle between them is mandatory.
- startMult asserted in the same cycle rst_n is released: the start is not accepted, because reset wins at that edge. It is accepted at the next edge if startMult is still high.

## Test plan
Defaults unless noted: WIDTH=16, nos=4, intDigits=16.
- Reset: hold rst_n=0 for 2 cycles with random inputs and startMult=1 → Res all 0x0000, endMult=0, no pulse in the next 10 cycles after any random reset-only stimulus.
- Outer product: C=0, u=[1,2,3,4], v=[1,0,−1,2], subMode=0, one-cycle start at edge k.
  - Res[0][0]=1, Res[2][2]=0xFFFD, Res[3][3]=8, Res[1][1]=0.
  - endMult high only between edges k+4 and k+5.
  - Row 2 is still 0 after edge k+2.
- Subtract and input capture: C=10·I, same u and v, subMode=1. Change C, u and v to 0 one cycle after start.
  - Res[0][0]=9, Res[3][3]=2, Res[2][0]=0xFFFD, Res[1][2]=2.
- Back-to-back: startMult held high for 20 cycles → endMult pulses exactly every 6 cycles. Each result matches the inputs present at its accepting edge.
- Reset mid-op: rst_n=0 at edge k+2 for one cycle, then start again.
  - Res=0 and no endMult for the aborted run.
  - The second run completes with the correct values.
- Fixed point (intDigits=8): u[0]=0x0180 (1.5), v[0]=0x0200 (2.0), C=0 → Res[0][0]=0x0300.
  - With u[0]=0xFE80 → 0xFD00.
  - u[0]=0x7F00, v[0]=0x0200 wraps to 0xFE00.
